// File: rtl/buck_current_regulator.sv
// buck_current_regulator: hysteretic (bang-bang) current loop for the discharge buck stage.
// Drives the high-side switch and the synchronous-rectifier low-side switch with dead time,
// minimum on/off times and a latched overcurrent trip. Gate outputs are registered and
// decoded from the next state so they move on the same edge as the state.
module buck_current_regulator #(
  parameter logic [15:0] HYST        = 16'd40,
  parameter logic [15:0] OC_LIMIT    = 16'd60000,
  parameter int unsigned DEAD_CYC    = 5,
  parameter int unsigned MIN_ON_CYC  = 10,
  parameter int unsigned MIN_OFF_CYC = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [15:0] i_set,
  input  logic [15:0] i_sense,
  input  logic        i_sense_valid,
  input  logic        fault_clear,
  output logic        mosfet_high,
  output logic        mosfet_low,
  output logic        oc_fault,
  output logic [15:0] pulse_count
);

  typedef enum logic [2:0] {
    IDLE,
    DEAD_TO_HIGH,
    HIGH_ON,
    DEAD_TO_LOW,
    LOW_ON,
    FAULT
  } state_e;

  // A dead-time state is left on the edge that ends its DEAD_CYC-th cycle, i.e. while
  // the dwell counter still reads DEAD_CYC-1.
  localparam logic [15:0] DeadLast = 16'(DEAD_CYC - 1);
  localparam logic [15:0] MinOn    = 16'(MIN_ON_CYC);
  localparam logic [15:0] MinOff   = 16'(MIN_OFF_CYC);

  state_e      state_q, state_d;
  logic [15:0] dwell_q, dwell_d;
  logic [15:0] pulseCnt_q, pulseCnt_d;
  logic        gateHigh_q, gateLow_q, fault_q;

  logic [16:0] hiSum;
  logic [15:0] hiTh;
  logic [15:0] loTh;
  logic        trip;
  logic        shutdown;
  logic        dwellSat;

  // Hysteresis band edges, recomputed every cycle from the live setpoint.
  always_comb begin
    hiSum = {1'b0, i_set} + {1'b0, HYST};
    hiTh  = hiSum[16] ? 16'hFFFF : hiSum[15:0];
    loTh  = (i_set > HYST) ? (i_set - HYST) : 16'd0;
  end

  // Next-state selection: trip beats shutdown, shutdown beats the normal hysteresis walk.
  always_comb begin
    trip     = i_sense_valid && (i_sense >= OC_LIMIT);
    shutdown = !enable || (i_set == 16'd0);
    state_d  = state_q;
    if (trip) begin
      state_d = FAULT;
    end else if (shutdown && (state_q != FAULT)) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = DEAD_TO_HIGH;
        end
        DEAD_TO_HIGH: begin
          if (dwell_q >= DeadLast) state_d = HIGH_ON;
        end
        HIGH_ON: begin
          if (i_sense_valid && (i_sense > hiTh) && (dwell_q >= MinOn)) state_d = DEAD_TO_LOW;
        end
        DEAD_TO_LOW: begin
          if (dwell_q >= DeadLast) state_d = LOW_ON;
        end
        LOW_ON: begin
          if (i_sense_valid && (i_sense < loTh) && (dwell_q >= MinOff)) state_d = DEAD_TO_HIGH;
        end
        FAULT: begin
          if (fault_clear && !enable) state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // Dwell counter restarts on any state change and sticks at full scale; pulse counter
  // counts completed dead-time-to-high handovers and wraps naturally.
  always_comb begin
    dwellSat   = (dwell_q == 16'hFFFF);
    dwell_d    = (state_d != state_q) ? 16'd0 : (dwellSat ? dwell_q : dwell_q + 16'd1);
    pulseCnt_d = pulseCnt_q;
    if ((state_q == DEAD_TO_HIGH) && (state_d == HIGH_ON)) pulseCnt_d = pulseCnt_q + 16'd1;
  end

  // State register with outputs decoded from the next state; reset drops both gates at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      dwell_q    <= 16'd0;
      pulseCnt_q <= 16'd0;
      gateHigh_q <= 1'b0;
      gateLow_q  <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      dwell_q    <= dwell_d;
      pulseCnt_q <= pulseCnt_d;
      gateHigh_q <= (state_d == HIGH_ON);
      gateLow_q  <= (state_d == LOW_ON);
      fault_q    <= (state_d == FAULT);
    end
  end

  assign mosfet_high = gateHigh_q;
  assign mosfet_low  = gateLow_q;
  assign oc_fault    = fault_q;
  assign pulse_count = pulseCnt_q;

endmodule

// File: tb/tb_buck_current_regulator.sv
// tb_buck_current_regulator: directed scenarios plus randomized stimulus for the hysteretic
// buck regulator, compared each cycle against a behavioural model of the control rules.
module tb_buck_current_regulator;

  localparam int HYST_V     = 40;
  localparam int OC_V       = 60000;
  localparam int DEAD_V     = 5;
  localparam int MIN_ON_V   = 10;
  localparam int MIN_OFF_V  = 10;

  // Model modes (independent numbering from the design)
  localparam int M_OFF      = 0;
  localparam int M_PRE_HIGH = 1;
  localparam int M_HIGH     = 2;
  localparam int M_PRE_LOW  = 3;
  localparam int M_LOW      = 4;
  localparam int M_TRIPPED  = 5;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic [15:0] i_set;
  logic [15:0] i_sense;
  logic        i_sense_valid;
  logic        fault_clear;
  logic        mosfet_high;
  logic        mosfet_low;
  logic        oc_fault;
  logic [15:0] pulse_count;

  int testCount = 0;
  int failCount = 0;

  int mMode;
  int mAge;
  int mPulses;

  buck_current_regulator #(
    .HYST        (16'(HYST_V)),
    .OC_LIMIT    (16'(OC_V)),
    .DEAD_CYC    (DEAD_V),
    .MIN_ON_CYC  (MIN_ON_V),
    .MIN_OFF_CYC (MIN_OFF_V)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .enable        (enable),
    .i_set         (i_set),
    .i_sense       (i_sense),
    .i_sense_valid (i_sense_valid),
    .fault_clear   (fault_clear),
    .mosfet_high   (mosfet_high),
    .mosfet_low    (mosfet_low),
    .oc_fault      (oc_fault),
    .pulse_count   (pulse_count)
  );

  // Free-running 10-unit clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    testCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  function automatic void modelReset();
    mMode   = M_OFF;
    mAge    = 0;
    mPulses = 0;
  endfunction

  // One clock of the control rules, applied to the inputs present at the edge.
  function automatic void modelStep();
    int setV, senseV, loV, hiV, nextMode;
    bit valid, tripNow, off;
    setV    = int'(i_set);
    senseV  = int'(i_sense);
    valid   = i_sense_valid;
    loV     = (setV > HYST_V) ? setV - HYST_V : 0;
    hiV     = (setV + HYST_V > 65535) ? 65535 : setV + HYST_V;
    tripNow = valid && (senseV >= OC_V);
    off     = !enable || (setV == 0);
    nextMode = mMode;
    if (tripNow) nextMode = M_TRIPPED;
    else if (off && mMode != M_TRIPPED) nextMode = M_OFF;
    else begin
      case (mMode)
        M_OFF:      nextMode = M_PRE_HIGH;
        M_PRE_HIGH: if (mAge + 1 == DEAD_V) nextMode = M_HIGH;
        M_HIGH:     if (valid && senseV > hiV && mAge >= MIN_ON_V) nextMode = M_PRE_LOW;
        M_PRE_LOW:  if (mAge + 1 == DEAD_V) nextMode = M_LOW;
        M_LOW:      if (valid && senseV < loV && mAge >= MIN_OFF_V) nextMode = M_PRE_HIGH;
        default:    if (fault_clear && !enable) nextMode = M_OFF;
      endcase
    end
    if (nextMode != mMode) begin
      if (mMode == M_PRE_HIGH && nextMode == M_HIGH) mPulses = (mPulses + 1) % 65536;
      mAge = 0;
    end else if (mAge < 65535) begin
      mAge = mAge + 1;
    end
    mMode = nextMode;
  endfunction

  // Drive one cycle of inputs, clock it, advance the model and compare all outputs.
  task automatic applyStimulus(input bit en, input int setV, input int senseV, input bit valid,
                               input bit clr);
    enable        = en;
    i_set         = 16'(setV);
    i_sense       = 16'(senseV);
    i_sense_valid = valid;
    fault_clear   = clr;
    @(posedge clk);
    modelStep();
    #1;
    checkOutput("high", int'(mosfet_high), (mMode == M_HIGH) ? 1 : 0);
    checkOutput("low", int'(mosfet_low), (mMode == M_LOW) ? 1 : 0);
    checkOutput("fault", int'(oc_fault), (mMode == M_TRIPPED) ? 1 : 0);
    checkOutput("pulses", int'(pulse_count), mPulses);
    checkOutput("overlap", int'(mosfet_high & mosfet_low), 0);
  endtask

  initial begin
    int curSet, s;
    bit en, clr, valid;
    rst_n = 1'b0;
    enable = 1'b0;
    i_set = 16'd0;
    i_sense = 16'd0;
    i_sense_valid = 1'b0;
    fault_clear = 1'b0;
    modelReset();
    #23 rst_n = 1'b1;
    #1;
    checkOutput("rstHigh", int'(mosfet_high), 0);
    checkOutput("rstLow", int'(mosfet_low), 0);
    checkOutput("rstFault", int'(oc_fault), 0);
    checkOutput("rstPulses", int'(pulse_count), 0);

    // Startup: five both-off cycles, then high side on
    for (int k = 1; k <= 6; k++) begin
      applyStimulus(1, 1000, 0, 0, 0);
      checkOutput("startHigh", int'(mosfet_high), (k == 6) ? 1 : 0);
    end
    checkOutput("startPulse", int'(pulse_count), 1);

    // Minimum on time: early sample discarded
    for (int k = 0; k < 3; k++) applyStimulus(1, 1000, 0, 0, 0);
    applyStimulus(1, 1000, 2000, 1, 0);
    checkOutput("minOnHold", int'(mosfet_high), 1);
    for (int k = 0; k < 6; k++) applyStimulus(1, 1000, 0, 0, 0);
    applyStimulus(1, 1000, 1040, 1, 0);
    checkOutput("band1040", int'(mosfet_high), 1);
    applyStimulus(1, 1000, 1041, 1, 0);
    checkOutput("cross1041", int'(mosfet_high), 0);
    for (int k = 1; k <= 5; k++) begin
      applyStimulus(1, 1000, 0, 0, 0);
      checkOutput("deadLow", int'(mosfet_low), (k == 5) ? 1 : 0);
    end

    // Low side back to high side
    for (int k = 0; k < 10; k++) applyStimulus(1, 1000, 0, 0, 0);
    applyStimulus(1, 1000, 960, 1, 0);
    checkOutput("band960", int'(mosfet_low), 1);
    applyStimulus(1, 1000, 959, 1, 0);
    checkOutput("cross959", int'(mosfet_low), 0);
    for (int k = 1; k <= 5; k++) begin
      applyStimulus(1, 1000, 0, 0, 0);
      checkOutput("deadHigh", int'(mosfet_high), (k == 5) ? 1 : 0);
    end
    checkOutput("secondPulse", int'(pulse_count), 2);

    // Overcurrent trip and clearing rules
    applyStimulus(1, 1000, 60000, 1, 0);
    checkOutput("tripGate", int'(mosfet_high), 0);
    checkOutput("tripFlag", int'(oc_fault), 1);
    applyStimulus(1, 1000, 0, 0, 1);
    checkOutput("clearWhileEn", int'(oc_fault), 1);
    applyStimulus(0, 1000, 0, 0, 1);
    checkOutput("clearDone", int'(oc_fault), 0);

    // Shutdown during dead time: high never asserted
    applyStimulus(1, 1000, 0, 0, 0);
    applyStimulus(1, 1000, 0, 0, 0);
    for (int k = 0; k < 8; k++) begin
      applyStimulus(1, 0, 0, 0, 0);
      checkOutput("shutNoHigh", int'(mosfet_high), 0);
    end

    // Tiny setpoint: lower threshold is zero, low side holds
    for (int k = 0; k < 16; k++) applyStimulus(1, 20, 0, 0, 0);
    applyStimulus(1, 20, 100, 1, 0);
    for (int k = 0; k < 5; k++) applyStimulus(1, 20, 0, 0, 0);
    for (int k = 0; k < 30; k++) begin
      applyStimulus(1, 20, 0, 1, 0);
      checkOutput("loThZero", int'(mosfet_low), 1);
    end

    // Asynchronous reset in the middle of a high-side pulse
    applyStimulus(0, 0, 0, 0, 0);
    for (int k = 0; k < 8; k++) applyStimulus(1, 1000, 0, 0, 0);
    checkOutput("preRstHigh", int'(mosfet_high), 1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("asyncHigh", int'(mosfet_high), 0);
    checkOutput("asyncLow", int'(mosfet_low), 0);
    checkOutput("asyncFault", int'(oc_fault), 0);
    checkOutput("asyncPulses", int'(pulse_count), 0);
    modelReset();
    #2 rst_n = 1'b1;

    // Randomized operation around several setpoints
    curSet = 1000;
    for (int n = 0; n < 4000; n++) begin
      if (n % 250 == 0) begin
        case ($urandom_range(0, 3))
          0:       curSet = 1000;
          1:       curSet = 20;
          2:       curSet = 65520;
          default: curSet = int'($urandom_range(1, 59000));
        endcase
      end
      en    = ($urandom_range(0, 149) != 0);
      clr   = ($urandom_range(0, 19) == 0);
      valid = ($urandom_range(0, 2) == 0);
      s = curSet + int'($urandom_range(0, 200)) - 100;
      if (s < 0) s = 0;
      if (s > 65535) s = 65535;
      if ($urandom_range(0, 299) == 0) s = OC_V + int'($urandom_range(0, 5535));
      if (n % 60 == 59) begin
        en  = 1'b0;
        clr = 1'b1;
      end
      applyStimulus(en, ($urandom_range(0, 149) == 0) ? 0 : curSet, s, valid, clr);
    end

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule

// File: doc/buck_current_regulator.md
# buck_current_regulator

Closed-loop consumer of the discharge current setpoint: takes `i_set` from the setpoint generator and the sampled gap current, and drives the buck high-side switch and the synchronous-rectifier low-side switch with hysteresis (bang-bang) control. Enforces dead time, minimum on/off times and a latched overcurrent trip. Sits between setpoint generation and the gate-driver pins in the discharge control path.

## Interface
Parameters:
- `HYST`, 16'd40: half-width of the hysteresis band, ADC codes.
- `OC_LIMIT`, 16'd60000: overcurrent trip threshold, ADC codes.
- `DEAD_CYC`, 5: dead-time length in clocks, ≥1.
- `MIN_ON_CYC`, 10: minimum high-side on time in clocks, ≥1.
- `MIN_OFF_CYC`, 10: minimum low-side on time in clocks, ≥1.

Ports:
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `enable`  in  1  regulator enable.
- `i_set`  in  16  current setpoint, unsigned ADC codes; 0 means off.
- `i_sense`  in  16  sampled gap current, unsigned ADC codes.
- `i_sense_valid`  in  1  one-cycle strobe; `i_sense` is valid this cycle.
- `fault_clear`  in  1  clears a latched fault.
- `mosfet_high`  out  1  high-side gate, active high.
- `mosfet_low`  out  1  low-side (synchronous rectifier) gate, active high.
- `oc_fault`  out  1  latched overcurrent flag.
- `pulse_count`  out  16  count of high-side turn-ons, wraps.

## Operation
- States: IDLE, DEAD_TO_HIGH, HIGH_ON, DEAD_TO_LOW, LOW_ON, FAULT.
- Thresholds, recomputed every cycle: `lo_th` = `i_set`−`HYST` if `i_set` > `HYST`, else 0. `hi_th` = `i_set`+`HYST` computed in 17 bits and saturated to 16'hFFFF.
- Priority per cycle, highest first:
  1. Trip: `i_sense_valid` && `i_sense` ≥ `OC_LIMIT` → FAULT from any state.
  2. Shutdown: `!enable` or `i_set`==0 → IDLE from any non-FAULT state.
  3. Normal transitions below.
- IDLE → DEAD_TO_HIGH when `enable` && `i_set`≠0.
- DEAD_TO_HIGH → HIGH_ON after exactly `DEAD_CYC` cycles in state.
- HIGH_ON → DEAD_TO_LOW when `i_sense_valid` && `i_sense` > `hi_th` && cycles-in-state ≥ `MIN_ON_CYC`.
- DEAD_TO_LOW → LOW_ON after exactly `DEAD_CYC` cycles.
- LOW_ON → DEAD_TO_HIGH when `i_sense_valid` && `i_sense` < `lo_th` && cycles-in-state ≥ `MIN_OFF_CYC`.
- FAULT → IDLE only when `fault_clear` && `!enable`; otherwise hold FAULT.
- A comparison whose min-time condition is not yet met is discarded. The controller waits for the next valid sample; nothing is remembered.
- Dwell counter: 16-bit, cleared on every state change, increments otherwise, saturates at 16'hFFFF.
- `pulse_count` increments (mod 2^16) on every DEAD_TO_HIGH → HIGH_ON transition.
- `oc_fault` sets on entry to FAULT, clears on FAULT → IDLE.
- `mosfet_high` and `mosfet_low` are never both 1. Every low→high or high→low handover passes through ≥ `DEAD_CYC` both-off cycles. Leaving via shutdown or trip drops both gates with no dead time.

## Timing
- Reset: state IDLE, dwell counter 0, `mosfet_high`=0, `mosfet_low`=0, `oc_fault`=0, `pulse_count`=0. Reset mid-operation forces both gates low immediately (asynchronous).
- All outputs are registered and decoded from next-state, so they change on the same edge the state changes:
  - `mosfet_high` = (next==HIGH_ON)
  - `mosfet_low` = (next==LOW_ON)
  - `oc_fault` = (next==FAULT)
- Sample to gate latency: a qualifying `i_sense_valid` in cycle N changes the gates at the edge ending cycle N.
- Dead time: entering DEAD_TO_x at edge E gives gates both 0 for exactly `DEAD_CYC` cycles; the new gate rises at edge E+`DEAD_CYC`.
- Simultaneous events: a trip and a hysteresis crossing in the same sample → FAULT. Shutdown during a dead-time state → IDLE, and the pending gate is never asserted.

## Test plan
- Startup: `HYST`=40, `DEAD_CYC`=5; reset, then `enable`=1, `i_set`=1000 → both gates 0 for 5 cycles, then `mosfet_high`=1 and `pulse_count`=1.
- Hysteresis: in HIGH_ON after 10 cycles, valid `i_sense`=1041 → 5 both-off cycles, then `mosfet_low`=1. In LOW_ON after 10 cycles, `i_sense`=959 → 5 both-off cycles, then high=1 and `pulse_count`=2. Samples of 1040 and 960 cause no switch.
- Minimum on time: valid `i_sense`=2000 at dwell count 3 in HIGH_ON → no change. The next valid sample at dwell ≥10 with `i_sense`=2000 → switches.
- Overcurrent: `i_sense`=60000 valid during HIGH_ON → next edge gates 0/0, `oc_fault`=1. `fault_clear` with `enable`=1 → stays FAULT. `enable`=0 plus `fault_clear` → IDLE, `oc_fault`=0.
- Shutdown and saturation: `i_set`=0 during DEAD_TO_HIGH → IDLE, high never asserted. `i_set`=20 gives `lo_th`=0, so high never re-asserts from LOW_ON. `i_set`=16'hFFF0 gives `hi_th`=16'hFFFF.
- Wrap and reset: preload 65535 turn-ons → `pulse_count` wraps to 0. Assert `rst_n`=0 mid HIGH_ON → gates drop immediately, all outputs at reset values.
